// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory-port arbiter and its requesters.
package mem_port_arbiter_pkg;

   // Access size encoding used by fetch, ld_st_unit and the memory port.
   localparam logic [1:0] DS_BYTE  = 2'd0;
   localparam logic [1:0] DS_WYDE  = 2'd1;
   localparam logic [1:0] DS_TETRA = 2'd2;
   localparam logic [1:0] DS_OCTA  = 2'd3;

   // One-hot grant indication: bit 0 fetch, bit 1 data.
   typedef logic [1:0] owner_t;
   localparam owner_t OWN_NONE  = 2'b00;
   localparam owner_t OWN_FETCH = 2'b01;
   localparam owner_t OWN_DATA  = 2'b10;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the shared memory port.
// master: the arbiter's view; slave: the requesters/memory view.
interface mem_port_arbiter_if;
   import mem_port_arbiter_pkg::*;

   logic [63:0] f_address;
   logic [1:0]  f_datasize;
   logic        f_read;
   logic [63:0] f_readdata;
   logic        f_done;

   logic [63:0] d_address;
   logic [1:0]  d_datasize;
   logic        d_read;
   logic        d_write;
   logic [63:0] d_writedata;
   logic [63:0] d_readdata;
   logic        d_done;

   logic [63:0] mem_address;
   logic [1:0]  mem_datasize;
   logic        mem_read;
   logic        mem_write;
   logic [63:0] mem_writedata;
   logic [63:0] mem_readdata;
   logic        mem_done;

   owner_t      owner;

   modport master (
      input  f_address, f_datasize, f_read,
      output f_readdata, f_done,
      input  d_address, d_datasize, d_read, d_write, d_writedata,
      output d_readdata, d_done,
      output mem_address, mem_datasize, mem_read, mem_write, mem_writedata,
      input  mem_readdata, mem_done,
      output owner
   );

   modport slave (
      output f_address, f_datasize, f_read,
      input  f_readdata, f_done,
      output d_address, d_datasize, d_read, d_write, d_writedata,
      input  d_readdata, d_done,
      input  mem_address, mem_datasize, mem_read, mem_write, mem_writedata,
      output mem_readdata, mem_done,
      input  owner
   );

endinterface

// File: rtl/mem_port_arbiter.sv
// Two-way arbiter sharing one memory port between instruction fetch and
// the load/store unit. Grant is held until mem_done or requester abort.
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | port free, no grant; mem_* driven to 0
// S_GNT_F | fetch owns the port; its request passes to memory
// S_GNT_D | load/store owns the port; its request passes to memory
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   mem_port_arbiter_if.master bus
);

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_GNT_F = 2'd1;
   localparam logic [1:0] S_GNT_D = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
   logic             f_pend, d_pend;

   assign f_pend = bus.f_read;
   assign d_pend = bus.d_read | bus.d_write;

   // Next grant; at completion the finishing owner's request is ignored so
   // the other side gets the port without an idle cycle.
   always_comb begin
      state_d = S_IDLE;
      case (state_q)
         S_IDLE: begin
            if (f_pend && d_pend)
               state_d = (starve_cnt_q == CNT_MAX) ? S_GNT_F : S_GNT_D;
            else if (f_pend)
               state_d = S_GNT_F;
            else if (d_pend)
               state_d = S_GNT_D;
         end
         S_GNT_F: begin
            if (bus.mem_done)
               state_d = d_pend ? S_GNT_D : S_IDLE;
            else if (f_pend)
               state_d = S_GNT_F;
         end
         S_GNT_D: begin
            if (bus.mem_done)
               state_d = f_pend ? S_GNT_F : S_IDLE;
            else if (d_pend)
               state_d = S_GNT_D;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Starvation count: data grants taken while fetch keeps waiting.
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (!bus.f_read)
         starve_cnt_d = '0;
      else if (state_d == S_GNT_F && state_q != S_GNT_F)
         starve_cnt_d = '0;
      else if (state_d == S_GNT_D && state_q != S_GNT_D && starve_cnt_q != CNT_MAX)
         starve_cnt_d = starve_cnt_q + CNT_W'(1);
   end

   // State and counter registers.
   always_ff @(posedge clk, negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         starve_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
      end
   end

   // Port mux keyed on the current grant; S_IDLE (also forced by reset)
   // drives every output to 0.
   always_comb begin
      bus.mem_address   = '0;
      bus.mem_datasize  = '0;
      bus.mem_read      = 1'b0;
      bus.mem_write     = 1'b0;
      bus.mem_writedata = '0;
      bus.f_done        = 1'b0;
      bus.f_readdata    = '0;
      bus.d_done        = 1'b0;
      bus.d_readdata    = '0;
      bus.owner         = OWN_NONE;
      case (state_q)
         S_GNT_F: begin
            bus.owner        = OWN_FETCH;
            bus.mem_address  = bus.f_address;
            bus.mem_datasize = bus.f_datasize;
            bus.mem_read     = bus.f_read;
            bus.f_done       = bus.mem_done;
            bus.f_readdata   = bus.mem_done ? bus.mem_readdata : '0;
         end
         S_GNT_D: begin
            bus.owner         = OWN_DATA;
            bus.mem_address   = bus.d_address;
            bus.mem_datasize  = bus.d_datasize;
            bus.mem_read      = bus.d_read;
            bus.mem_write     = bus.d_write;
            bus.mem_writedata = bus.d_writedata;
            bus.d_done        = bus.mem_done;
            bus.d_readdata    = bus.mem_done ? bus.mem_readdata : '0;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a
// randomized run against a grant-level reference model.
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   logic clk;
   logic reset_n;
   int   checks   = 0;
   int   failures = 0;

   mem_port_arbiter_if bus();

   mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Step to just after the next rising edge; inputs are driven here.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_inputs();
      bus.f_address     = '0;
      bus.f_datasize    = '0;
      bus.f_read        = 1'b0;
      bus.d_address     = '0;
      bus.d_datasize    = '0;
      bus.d_read        = 1'b0;
      bus.d_write       = 1'b0;
      bus.d_writedata   = '0;
      bus.mem_readdata  = '0;
      bus.mem_done      = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      logic [331:0] all_out;
      clear_inputs();
      reset_n = 1'b0;
      bus.mem_done = 1'b1;
      bus.mem_readdata = 64'h1234;
      tick();
      #1;
      all_out = {bus.mem_address, bus.mem_datasize, bus.mem_read, bus.mem_write,
                 bus.mem_writedata, bus.f_done, bus.d_done, bus.f_readdata,
                 bus.d_readdata, bus.owner};
      checks++;
      if (all_out !== '0) begin
         failures++;
         $display("FAIL reset_outputs: got %h required 0", all_out);
      end
      reset_n = 1'b1;
      clear_inputs();
      tick();
   endtask

   task automatic test_fetch_only();
      do_reset();
      bus.f_read = 1'b1;
      bus.f_address = 64'h100;
      bus.f_datasize = DS_OCTA;
      #1;
      checks++;
      if (bus.owner !== OWN_NONE || bus.mem_read !== 1'b0) begin
         failures++;
         $display("FAIL fetch_latency: owner=%b mem_read=%b required 00/0", bus.owner, bus.mem_read);
      end
      tick();
      #1;
      checks++;
      if (bus.mem_read !== 1'b1 || bus.mem_address !== 64'h100 || bus.mem_datasize !== DS_OCTA
          || bus.owner !== OWN_FETCH || bus.mem_write !== 1'b0) begin
         failures++;
         $display("FAIL fetch_grant: rd=%b addr=%h ds=%0d owner=%b required 1/100/3/01",
                  bus.mem_read, bus.mem_address, bus.mem_datasize, bus.owner);
      end
      tick();
      tick();
      bus.mem_done = 1'b1;
      bus.mem_readdata = 64'hDEADBEEF;
      #1;
      checks++;
      if (bus.f_done !== 1'b1 || bus.f_readdata !== 64'hDEADBEEF || bus.d_done !== 1'b0
          || bus.d_readdata !== 64'h0) begin
         failures++;
         $display("FAIL fetch_done: f_done=%b f_rd=%h d_done=%b required 1/deadbeef/0",
                  bus.f_done, bus.f_readdata, bus.d_done);
      end
      tick();
      bus.mem_done = 1'b0;
      bus.f_read = 1'b0;
      #1;
      checks++;
      if (bus.owner !== OWN_NONE || bus.f_done !== 1'b0 || bus.mem_read !== 1'b0) begin
         failures++;
         $display("FAIL fetch_release: owner=%b f_done=%b required 00/0", bus.owner, bus.f_done);
      end
   endtask

   task automatic test_data_store();
      do_reset();
      bus.d_write = 1'b1;
      bus.d_datasize = DS_BYTE;
      bus.d_writedata = 64'hAB;
      bus.d_address = 64'h2000;
      tick();
      #1;
      checks++;
      if (bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0 || bus.mem_datasize !== DS_BYTE
          || bus.mem_writedata !== 64'hAB || bus.mem_address !== 64'h2000 || bus.owner !== OWN_DATA) begin
         failures++;
         $display("FAIL store_grant: wr=%b rd=%b ds=%0d wd=%h owner=%b required 1/0/0/ab/10",
                  bus.mem_write, bus.mem_read, bus.mem_datasize, bus.mem_writedata, bus.owner);
      end
      tick();
      bus.mem_done = 1'b1;
      #1;
      checks++;
      if (bus.d_done !== 1'b1 || bus.f_done !== 1'b0) begin
         failures++;
         $display("FAIL store_done: d_done=%b f_done=%b required 1/0", bus.d_done, bus.f_done);
      end
      tick();
      bus.mem_done = 1'b0;
      bus.d_write = 1'b0;
      #1;
      checks++;
      if (bus.d_done !== 1'b0 || bus.f_done !== 1'b0 || bus.owner !== OWN_NONE || bus.mem_write !== 1'b0) begin
         failures++;
         $display("FAIL store_release: d_done=%b f_done=%b owner=%b required 0/0/00",
                  bus.d_done, bus.f_done, bus.owner);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      bus.f_read = 1'b1;
      bus.f_address = 64'h200;
      bus.d_read = 1'b1;
      bus.d_address = 64'h300;
      tick();
      #1;
      checks++;
      if (bus.owner !== OWN_DATA || bus.mem_address !== 64'h300) begin
         failures++;
         $display("FAIL tie_data_first: owner=%b addr=%h required 10/300", bus.owner, bus.mem_address);
      end
      tick();
      bus.mem_done = 1'b1;
      bus.mem_readdata = 64'h5555_AAAA;
      #1;
      checks++;
      if (bus.d_done !== 1'b1 || bus.d_readdata !== 64'h5555_AAAA || bus.f_done !== 1'b0
          || bus.f_readdata !== 64'h0) begin
         failures++;
         $display("FAIL tie_data_done: d_done=%b d_rd=%h f_done=%b required 1/5555aaaa/0",
                  bus.d_done, bus.d_readdata, bus.f_done);
      end
      tick();
      bus.mem_done = 1'b0;
      bus.d_read = 1'b0;
      #1;
      checks++;
      if (bus.owner !== OWN_FETCH || bus.mem_address !== 64'h200 || bus.mem_read !== 1'b1) begin
         failures++;
         $display("FAIL b2b_no_idle: owner=%b addr=%h required 01/200", bus.owner, bus.mem_address);
      end
      tick();
      bus.mem_done = 1'b1;
      bus.mem_readdata = 64'h77;
      #1;
      checks++;
      if (bus.f_done !== 1'b1 || bus.f_readdata !== 64'h77 || bus.d_done !== 1'b0) begin
         failures++;
         $display("FAIL b2b_fetch_done: f_done=%b f_rd=%h required 1/77", bus.f_done, bus.f_readdata);
      end
      tick();
      clear_inputs();
   endtask

   task automatic test_starvation();
      do_reset();
      bus.f_read = 1'b1;
      bus.f_address = 64'hF00;
      bus.d_read = 1'b1;
      bus.d_address = 64'hD00;
      for (int k = 1; k <= 4; k++) begin
         tick();
         #1;
         checks++;
         if (bus.owner !== OWN_DATA) begin
            failures++;
            $display("FAIL starve_data_grant%0d: owner=%b required 10", k, bus.owner);
         end
         bus.d_read = 1'b0;
         tick();
         bus.d_read = 1'b1;
      end
      tick();
      #1;
      checks++;
      if (bus.owner !== OWN_FETCH || bus.mem_address !== 64'hF00) begin
         failures++;
         $display("FAIL starve_fetch_forced: owner=%b addr=%h required 01/f00", bus.owner, bus.mem_address);
      end
      bus.mem_done = 1'b1;
      tick();
      bus.mem_done = 1'b0;
      #1;
      checks++;
      if (bus.owner !== OWN_DATA) begin
         failures++;
         $display("FAIL starve_after_fetch: owner=%b required 10", bus.owner);
      end
      bus.d_read = 1'b0;
      tick();
      bus.d_read = 1'b1;
      tick();
      #1;
      checks++;
      if (bus.owner !== OWN_DATA) begin
         failures++;
         $display("FAIL starve_cnt_cleared: owner=%b required 10", bus.owner);
      end
      clear_inputs();
      tick();
   endtask

   task automatic test_abort();
      do_reset();
      bus.d_read = 1'b1;
      bus.d_address = 64'h440;
      tick();
      bus.d_read = 1'b0;
      #1;
      checks++;
      if (bus.owner !== OWN_DATA || bus.mem_read !== 1'b0 || bus.d_done !== 1'b0) begin
         failures++;
         $display("FAIL abort_drop: owner=%b rd=%b d_done=%b required 10/0/0",
                  bus.owner, bus.mem_read, bus.d_done);
      end
      tick();
      bus.mem_done = 1'b1;
      bus.mem_readdata = 64'h99;
      #1;
      checks++;
      if (bus.owner !== OWN_NONE || bus.d_done !== 1'b0 || bus.f_done !== 1'b0 || bus.d_readdata !== 64'h0) begin
         failures++;
         $display("FAIL abort_late_done: owner=%b d_done=%b f_done=%b required 00/0/0",
                  bus.owner, bus.d_done, bus.f_done);
      end
      tick();
      bus.mem_done = 1'b0;
      #1;
      checks++;
      if (bus.owner !== OWN_NONE) begin
         failures++;
         $display("FAIL abort_stay_idle: owner=%b required 00", bus.owner);
      end
   endtask

   task automatic test_reset_mid();
      logic [331:0] all_out;
      do_reset();
      bus.f_read = 1'b1;
      bus.f_address = 64'h880;
      tick();
      bus.mem_done = 1'b1;
      bus.mem_readdata = 64'hCAFE;
      #1;
      reset_n = 1'b0;
      #1;
      all_out = {bus.mem_address, bus.mem_datasize, bus.mem_read, bus.mem_write,
                 bus.mem_writedata, bus.f_done, bus.d_done, bus.f_readdata,
                 bus.d_readdata, bus.owner};
      checks++;
      if (all_out !== '0) begin
         failures++;
         $display("FAIL reset_mid_grant: got %h required 0", all_out);
      end
      clear_inputs();
      tick();
      reset_n = 1'b1;
      tick();
   endtask

   // Randomized run against a grant-level model: the model tracks who owns
   // the port and how many data grants fetch has waited through.
   task automatic test_random();
      int          m_own;   // 0 none, 1 fetch, 2 data
      int          m_cnt;
      int          nxt;
      int          shown;
      bit          fp, dp;
      logic [1:0]  e_owner;
      logic [3:0]  e_ctl, a_ctl;
      logic [129:0] e_dat, a_dat;
      do_reset();
      m_own = 0;
      m_cnt = 0;
      shown = 0;
      for (int n = 0; n < 600; n++) begin
         bus.f_read       = ($urandom_range(0, 9) < 7);
         bus.d_read       = ($urandom_range(0, 9) < 4);
         bus.d_write      = ($urandom_range(0, 9) < 3);
         bus.mem_done     = ($urandom_range(0, 9) < 3);
         bus.f_address    = {$urandom, $urandom};
         bus.d_address    = {$urandom, $urandom};
         bus.f_datasize   = 2'($urandom_range(0, 3));
         bus.d_datasize   = 2'($urandom_range(0, 3));
         bus.d_writedata  = {$urandom, $urandom};
         bus.mem_readdata = {$urandom, $urandom};
         #1;
         fp = bus.f_read;
         dp = bus.d_read | bus.d_write;
         e_owner = (m_own == 1) ? OWN_FETCH : (m_own == 2) ? OWN_DATA : OWN_NONE;
         if (m_own == 1) begin
            e_ctl = {bus.f_read, 1'b0, bus.mem_done, 1'b0};
            e_dat = {bus.f_address, bus.f_datasize, 64'h0};
         end else if (m_own == 2) begin
            e_ctl = {bus.d_read, bus.d_write, 1'b0, bus.mem_done};
            e_dat = {bus.d_address, bus.d_datasize, bus.d_writedata};
         end else begin
            e_ctl = 4'b0;
            e_dat = '0;
         end
         a_ctl = {bus.mem_read, bus.mem_write, bus.f_done, bus.d_done};
         a_dat = {bus.mem_address, bus.mem_datasize, bus.mem_writedata};
         checks++;
         if (bus.owner !== e_owner || a_ctl !== e_ctl || a_dat !== e_dat) begin
            failures++;
            if (shown < 8)
               $display("FAIL random_cycle%0d: owner=%b ctl=%b got_dat=%h required owner=%b ctl=%b dat=%h",
                        n, bus.owner, a_ctl, a_dat, e_owner, e_ctl, e_dat);
            shown++;
         end
         if (bus.mem_done && m_own != 0) begin
            checks++;
            if ((m_own == 1 && (bus.f_readdata !== bus.mem_readdata || bus.d_readdata !== 64'h0)) ||
                (m_own == 2 && (bus.d_readdata !== bus.mem_readdata || bus.f_readdata !== 64'h0))) begin
               failures++;
               if (shown < 8)
                  $display("FAIL random_rdata%0d: f_rd=%h d_rd=%h required mem_rd=%h to owner %0d",
                           n, bus.f_readdata, bus.d_readdata, bus.mem_readdata, m_own);
               shown++;
            end
         end
         // Who holds the port next cycle.
         nxt = m_own;
         if (m_own == 0) begin
            if (fp && dp) nxt = (m_cnt >= 4) ? 1 : 2;
            else if (fp)  nxt = 1;
            else if (dp)  nxt = 2;
         end else if (bus.mem_done) begin
            if (m_own == 1) nxt = dp ? 2 : 0;
            else            nxt = fp ? 1 : 0;
         end else if ((m_own == 1 && !fp) || (m_own == 2 && !dp)) begin
            nxt = 0;
         end
         if (!fp)                          m_cnt = 0;
         else if (nxt == 1 && m_own != 1)  m_cnt = 0;
         else if (nxt == 2 && m_own != 2)  m_cnt = (m_cnt < 4) ? m_cnt + 1 : 4;
         m_own = nxt;
         tick();
      end
      clear_inputs();
      tick();
   endtask

   initial begin
      reset_n = 1'b0;
      clear_inputs();
      test_reset();
      test_fetch_only();
      test_data_store();
      test_back_to_back();
      test_starvation();
      test_abort();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single memory port between instruction fetch and the load/store unit (`ld_st_unit`, inside `exec_unit`). Each requester sees the same level-hold request / one-cycle `done` protocol that the memory already offers. The block grants one requester at a time and holds that grant until `mem_done`. Data requests win ties, and a starvation counter guarantees fetch progress.

## Interface
Parameters:
- `STARVE_LIMIT`, 4: consecutive data grants allowed while fetch waits before fetch is forced.

Ports:
- `clk`  in  1  clock
- `reset_n`  in  1  reset; asynchronous, active-low
- `f_address`  in  64  fetch address
- `f_datasize`  in  2  0 byte, 1 wyde, 2 tetra, 3 octa
- `f_read`  in  1  fetch read request, level-held
- `f_readdata`  out  64  read data to fetch
- `f_done`  out  1  one-cycle completion pulse to fetch
- `d_address`  in  64  data address
- `d_datasize`  in  2  data size, same encoding as `f_datasize`
- `d_read`  in  1  data read request, level-held
- `d_write`  in  1  data write request, level-held
- `d_writedata`  in  64  data write data
- `d_readdata`  out  64  read data to the load/store side
- `d_done`  out  1  one-cycle completion pulse to the load/store side
- `mem_address`  out  64  to memory
- `mem_datasize`  out  2  to memory
- `mem_read`  out  1  to memory
- `mem_write`  out  1  to memory
- `mem_writedata`  out  64  to memory
- `mem_readdata`  in  64  from memory
- `mem_done`  in  1  from memory
- `owner`  out  2  one-hot current grant: [0] fetch, [1] data; 00 when idle

## Operation
- States: `S_IDLE`, `S_GNT_F`, `S_GNT_D`; the state register resets to `S_IDLE`.
- A request is pending when `f_read` is high (fetch), or when `d_read | d_write` is high (data).
- `S_IDLE` transitions:
  - Only one side pending: grant that side next cycle.
  - Both pending: grant data, unless `starve_cnt == STARVE_LIMIT`, in which case grant fetch.
- While granted, the owner's signals pass combinationally to the `mem_*` outputs.
  - Fetch owner: `mem_write = 0`, `mem_writedata = 0`.
  - Not granted: all `mem_*` outputs are 0.
- Completion in the cycle `mem_done` is high while granted:
  - The owner's `x_done` is 1 and `x_readdata = mem_readdata`, both combinational.
  - The non-owner's `done` is 0 and its `readdata` is 0.
- Next state at completion is chosen ignoring the current owner's still-high request:
  - Other side pending: go directly to its grant, with no idle cycle.
  - Otherwise: `S_IDLE`.
- Abort: owner's request low while granted with `mem_done` low.
  - Next state is `S_IDLE` and no `done` is issued.
  - A later `mem_done` while idle is ignored.
- `mem_done` in `S_IDLE` is ignored: no `done`, and no state change.
- `starve_cnt` (saturating, width `$clog2(STARVE_LIMIT+1)`):
  - Increments on each data grant taken while `f_read` is high.
  - Clears on any fetch grant.
  - Clears in any cycle `f_read` is low.
- `d_write` and `d_read` both high: forwarded as-is; memory decides. CSWAP issues read then write as two separate requests, each with its own grant.

## Timing
- Arbitration latency: a request first seen in cycle N, with the port idle, reaches `mem_*` in cycle N+1.
- `done` latency: zero cycles after `mem_done`.
- Back-to-back: the other requester's `mem_*` request appears in the cycle after the previous `mem_done`.
- Reset mid-transaction: state goes to `S_IDLE` immediately. While `reset_n` is low, all outputs are 0: `mem_*`, `f_done`, `d_done`, `f_readdata`, `d_readdata`, `owner`.
- Requester contract: address, size and writedata stay stable from the request until `done`. The arbiter does not latch them.

## Structure
- Shared package: the datasize encoding constants (`DS_BYTE`, `DS_WYDE`, `DS_TETRA`, `DS_OCTA`), already implicit in `ld_st_unit`, and the owner one-hot encoding.
- Single module, with no sub-modules. The mux is an `always_comb` block keyed on state, and the state and counter sit in one `always_ff @(posedge clk, negedge reset_n)` block.

## Test plan
- Fetch only: `f_read=1`, `f_address=0x100`, memory returns `0xDEADBEEF` after 3 cycles.
  - Required: `mem_read` high from cycle 1, `f_done` pulses with `f_readdata=0xDEADBEEF`, `owner` returns to 00.
- Data store alone: `d_write=1`, `d_datasize=0`, `d_writedata=0xAB`.
  - Required: `mem_write=1`, `mem_datasize=0`, `mem_writedata=0xAB`, `d_done` for 1 cycle, `f_done` stays 0.
- Simultaneous request, counter at 0: both requesters assert in the same cycle.
  - Required: data granted first. `mem_address` switches to `f_address` the cycle after `d_done`, with no idle cycle.
- Starvation: data re-requests continuously while `f_read` is held.
  - Required: after 4 data grants, the fifth grant goes to fetch and `starve_cnt` clears.
- Abort and reset:
  - Data owner drops `d_read` before `mem_done`: `S_IDLE` next cycle, and a subsequent `mem_done` produces no `done`.
  - `reset_n` pulled low mid-grant: all outputs 0 immediately.
